custom_protocol_tx: RTL

Frame transmitter that sits directly upstream of the 4-lane custom protocol receiver and drives its data/strobe/direction pins.
- Accepts a 16-bit payload plus direction over a valid/ready handshake.
- Emits a start condition (bit-0 toggle), then four strobed 4-bit beats, then a checksum-evaluation hold cycle and a holdoff.
- Reports the per-beat parity nibble that the receiver is expected to compute.

---
 rtl/custom_protocol_tx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/custom_protocol_tx.sv
// Four-lane frame transmitter: start toggle, four strobed nibble beats, checksum
// hold cycle and holdoff. All outputs are registered.
//
// state   | meaning
// IDLE    | waiting for tx_valid && tx_ready, bus_data held
// START   | toggle bus_data[0] to mark frame start
// DATA    | drive beat k with strobe high, accumulate parity bit k
// GAP     | strobe low between beats, bus_data held
// CHECK   | done pulse, publish checksum nibble
// HOLDOFF | idle spacing before tx_ready reasserts, direction still driven
module custom_protocol_tx #(
  parameter int GAP_CYCLES     = 0,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        tx_dir,
  input  logic [15:0] tx_data,
  output logic [3:0]  bus_data,
  output logic        strobe,
  output logic        direction,
  output logic        busy,
  output logic        done,
  output logic [3:0]  frame_checksum
);

  typedef enum logic [2:0] {IDLE, START, DATA, GAP, CHECK, HOLDOFF} state_t;

  // Down-counters load N-1 and expire on zero, giving exactly N cycles in state.
  localparam logic [3:0] GAP_LOAD  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [3:0] HOLD_LOAD = 4'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  state_t      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] payload_q, payload_d;
  logic [3:0]  acc_q, acc_d;
  logic [3:0]  bus_q, bus_d;
  logic        strobe_q, strobe_d;
  logic        dir_q, dir_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  cksum_q, cksum_d;
  logic        ready_q, ready_d;
  logic [3:0]  beat_nib;

  always_comb begin
    beat_nib = 4'h0;
    for (int l = 0; l < 4; l++) begin
      beat_nib[l] = payload_q[4*l + int'(beat_q)];
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    acc_d     = acc_q;
    bus_d     = bus_q;
    strobe_d  = 1'b0;
    dir_d     = dir_q;
    done_d    = 1'b0;
    cksum_d   = cksum_q;
    ready_d   = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (tx_valid && ready_q) begin
          payload_d = tx_data;
          dir_d     = tx_dir;
          ready_d   = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        bus_d   = {bus_q[3:1], ~bus_q[0]};
        acc_d   = 4'h0;
        beat_d  = 2'd0;
        state_d = DATA;
      end
      DATA: begin
        bus_d         = beat_nib;
        strobe_d      = 1'b1;
        acc_d[beat_q] = ^beat_nib;
        if (beat_q == 2'd3) begin
          state_d = CHECK;
        end else begin
          beat_d = beat_q + 2'd1;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (cnt_q == 4'd0) state_d = DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CHECK: begin
        done_d  = 1'b1;
        cksum_d = acc_q;
        cnt_d   = HOLD_LOAD;
        state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= 2'd0;
      cnt_q     <= 4'd0;
      payload_q <= 16'h0;
      acc_q     <= 4'h0;
      bus_q     <= 4'h0;
      strobe_q  <= 1'b0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cksum_q   <= 4'h0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      acc_q     <= acc_d;
      bus_q     <= bus_d;
      strobe_q  <= strobe_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cksum_q   <= cksum_d;
      ready_q   <= ready_d;
    end
  end

  assign tx_ready       = ready_q;
  assign bus_data       = bus_q;
  assign strobe         = strobe_q;
  assign direction      = dir_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign frame_checksum = cksum_q;

endmodule
